dsss_spreader: RTL and testbench
================================

# dsss_spreader

Parametrised direct-sequence spreader. Each accepted information bit is XOR-ed with SF pseudo-random chips from an internal LFSR. The spreading factor is set at run time, and two code modes are supported: a fixed code repeated for every bit, or a running code that produces fresh chips for every bit. The block sits between the bit source and the chip-rate modulator. It has valid/ready handshakes on both sides, including output backpressure, and a one-deep input buffer so that bits stream back-to-back without gaps.

## Interface
- SF_MAX, 32: largest supported spreading factor; sizes the code register.
- SF_DEFAULT, 24: spreading factor in force after reset.
- LFSR_W, 9: LFSR length.
- LFSR_POLY, 9'h110: Fibonacci feedback taps (x^9+x^5+1).
- LFSR_SEED, 9'h1FF: LFSR load value; must be non-zero.
- SF_W, $clog2(SF_MAX+1): width of the spreading-factor fields.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_sf  in  SF_W  requested spreading factor, sampled on i_cfg_load.
- i_mode  in  1  code mode, sampled on i_cfg_load: 0 = fixed code, 1 = running code.
- i_cfg_load  in  1  one-cycle pulse requesting reconfiguration.
- i_data  in  1  information bit.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block can accept a bit this cycle.
- o_data  out  1  chip.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts the chip.
- o_last  out  1  chip is the last chip of its bit.
- o_busy  out  1  code generation in progress, or a bit in flight or buffered.

## Operation
- Input handshake: a bit is taken when i_valid && o_ready. Output handshake: a chip is consumed when o_valid && i_ready.
- SF clamping at load: values below 2 become 2; values above SF_MAX become SF_MAX.
- State FILL:
  - LFSR reloaded with LFSR_SEED.
  - Fixed mode: SF cycles, chip k = LFSR output bit on step k, stored in code[k].
  - Running mode: 1 cycle (seed reload only).
  - Then IDLE.
- State IDLE: o_ready=1, o_valid=0. An accepted bit moves to the active register; next state SPREAD.
- State SPREAD:
  - o_valid=1.
  - o_data = active_bit ^ (fixed ? code[idx] : lfsr_out).
  - idx and, in running mode, the LFSR advance only on a chip handshake.
  - o_last = (idx == SF-1).
- Input buffering:
  - o_ready stays 1 while the one-deep buffer is empty and no config load is pending.
  - On the last chip's handshake, a buffered bit (or one arriving that same cycle) becomes active, idx=0, and the block stays in SPREAD.
  - Otherwise it returns to IDLE.
- Config load:
  - In IDLE: latch sf/mode, go to FILL next cycle.
  - In SPREAD/FILL: the request is held pending; o_ready=0 until the active and buffered bits drain, then FILL.
  - A second pulse while pending overwrites the latched values.
- After reset: sf=SF_DEFAULT, mode=fixed, state FILL.
- No chip is dropped or duplicated under any i_ready pattern.
- Running mode: the LFSR is never reseeded between bits, only on reset or config load.

## Timing
- Reset values: o_ready=0, o_valid=0, o_data=0, o_last=0, o_busy=1 (FILL). All internal registers cleared; LFSR = LFSR_SEED.
- Reset mid-operation aborts the current bit immediately; chips are not resumed.
- Latency: bit accepted in cycle N gives its first chip valid in cycle N+1.
- Throughput: SF chips per bit at i_ready=1; zero bubble cycles between consecutive bits when the buffer is fed.
- Output stability: o_data/o_last are held stable while o_valid && !i_ready.
- FILL duration: exactly SF cycles (fixed) or 1 cycle (running). o_ready=0 throughout.
- Simultaneous last-chip handshake and input accept: the new bit goes straight to active; the buffer stays empty.

## Structure
- Package dsss_pkg: mode enum (MODE_FIXED, MODE_RUNNING), state enum (FILL, IDLE, SPREAD), default polynomial/seed constants.
- Sub-module lfsr_gen (params WIDTH, POLY, SEED; ports i_clk, i_reset, i_load, i_step, o_bit). Shared with the despreader.
- Top contains the FSM, the code register, the idx counter and the input buffer.

## Test plan
- Reset, then SF_DEFAULT=24, fixed mode: o_ready rises exactly 24 cycles after reset release. Bits 1,0 give 48 chips; chips 24..47 are the bitwise complement of chips 0..23; o_last at chips 23 and 47.
- cfg_load sf=4, mode fixed, i_ready=1, 3 bits streamed back-to-back: 12 consecutive valid chips with no gap. Pattern repeats per bit, XOR-ed with the bit. o_last on every 4th chip.
- Running mode, sf=8, two bits both 0: chips 0..15 equal the first 16 lfsr_gen outputs from seed, against a model. The second group differs from the first.
- Random i_ready (50%) with sf=5: the chip sequence matches the i_ready=1 run exactly, and o_data is stable during stalls.
- cfg_load sf=1 and sf=40 (SF_MAX=32): effective SF is 2 and 32. cfg_load mid-bit is deferred until the current and buffered bits complete.
- i_reset asserted at chip 3 of a bit: all outputs reach their reset values asynchronously. After release, a FILL of SF_DEFAULT cycles precedes o_ready.

Source files
------------

// File: rtl/dsss_pkg.sv
// Shared types and default LFSR constants for the DSSS spreader/despreader pair.
package dsss_pkg;

  typedef enum logic {
    MODE_FIXED   = 1'b0,
    MODE_RUNNING = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    IDLE   = 2'd1,
    SPREAD = 2'd2
  } state_e;

  localparam int         DEF_LFSR_W    = 9;
  localparam logic [8:0] DEF_LFSR_POLY = 9'h110;  // x^9 + x^5 + 1
  localparam logic [8:0] DEF_LFSR_SEED = 9'h1FF;

endpackage

// File: rtl/dsss_spreader_lfsr.sv
// Fibonacci LFSR chip source; output is the MSB, feedback enters at bit 0.
module lfsr_gen
  import dsss_pkg::*;
#(
  parameter int               WIDTH = DEF_LFSR_W,
  parameter logic [WIDTH-1:0] POLY  = DEF_LFSR_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEF_LFSR_SEED
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_step,
  output logic o_bit
);

  logic [WIDTH-1:0] state;
  logic             feedback;

  assign feedback = ^(state & POLY);
  assign o_bit    = state[WIDTH-1];

  // Load wins over step so a reseed is never lost to a coincident chip advance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     state <= SEED;
    else if (i_load) state <= SEED;
    else if (i_step) state <= {state[WIDTH-2:0], feedback};
  end

endmodule

// File: rtl/dsss_spreader.sv
// Direct-sequence spreader: each input bit is XOR-ed with SF chips, either from a
// stored code (fixed mode) or straight from a free-running LFSR (running mode).
module dsss_spreader
  import dsss_pkg::*;
#(
  parameter int                SF_MAX     = 32,
  parameter int                SF_DEFAULT = 24,
  parameter int                LFSR_W     = 9,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 9'h110,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 9'h1FF,
  parameter int                SF_W       = $clog2(SF_MAX + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [SF_W-1:0] i_sf,
  input  logic            i_mode,
  input  logic            i_cfg_load,
  input  logic            i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last,
  output logic            o_busy
);

  localparam int              IDX_W  = $clog2(SF_MAX);
  localparam logic [SF_W-1:0] SF_LO  = SF_W'(2);
  localparam logic [SF_W-1:0] SF_HI  = SF_W'(SF_MAX);
  localparam logic [SF_W-1:0] SF_RST = SF_W'(SF_DEFAULT);

  function automatic logic [SF_W-1:0] clamp_sf(input logic [SF_W-1:0] sf_in);
    if (sf_in < SF_LO) return SF_LO;
    if (sf_in > SF_HI) return SF_HI;
    return sf_in;
  endfunction

  state_e            state;
  mode_e             mode, pend_mode, cfg_mode;
  logic [SF_W-1:0]   sf, pend_sf, cfg_sf;
  logic              pend;
  logic [IDX_W-1:0]  idx, idx_last;
  logic [SF_MAX-1:0] code;
  logic              active_bit, buf_valid, buf_bit;
  logic              accept, chip_hs, at_last, fill_done, go_fill, cfg_req;
  logic              lfsr_bit, lfsr_step;

  always_comb begin
    cfg_req   = i_cfg_load | pend;
    cfg_sf    = i_cfg_load ? clamp_sf(i_sf) : pend_sf;
    cfg_mode  = i_cfg_load ? mode_e'(i_mode) : pend_mode;
    idx_last  = IDX_W'(sf - 1'b1);
    at_last   = (idx == idx_last);
    o_valid   = (state == SPREAD);
    // A pending reconfiguration closes the input so the in-flight bits can drain.
    o_ready   = !pend && ((state == IDLE) || (state == SPREAD && !buf_valid));
    accept    = i_valid && o_ready;
    chip_hs   = o_valid && i_ready;
    fill_done = (mode == MODE_RUNNING) || at_last;
    go_fill   = 1'b0;
    case (state)
      FILL:    go_fill = fill_done && cfg_req;
      IDLE:    go_fill = cfg_req && !accept;
      SPREAD:  go_fill = chip_hs && at_last && !buf_valid && !accept && cfg_req;
      default: go_fill = 1'b0;
    endcase
    lfsr_step = (state == FILL && mode == MODE_FIXED) ||
                (state == SPREAD && mode == MODE_RUNNING && chip_hs);
    o_data    = o_valid && (active_bit ^ ((mode == MODE_FIXED) ? code[idx] : lfsr_bit));
    o_last    = o_valid && at_last;
    o_busy    = (state != IDLE) || pend;
  end

  lfsr_gen #(
    .WIDTH(LFSR_W),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_load (go_fill),
    .i_step (lfsr_step),
    .o_bit  (lfsr_bit)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= FILL;
      mode       <= MODE_FIXED;
      sf         <= SF_RST;
      pend       <= 1'b0;
      pend_sf    <= '0;
      pend_mode  <= MODE_FIXED;
      idx        <= '0;
      // NOTE: the code store is a flat register, so it is cleared like any other state.
      code       <= '0;
      active_bit <= 1'b0;
      buf_valid  <= 1'b0;
      buf_bit    <= 1'b0;
    end else begin
      if (i_cfg_load) begin
        pend      <= 1'b1;
        pend_sf   <= clamp_sf(i_sf);
        pend_mode <= mode_e'(i_mode);
      end
      if (go_fill) begin
        state <= FILL;
        sf    <= cfg_sf;
        mode  <= cfg_mode;
        pend  <= 1'b0;
        idx   <= '0;
      end else begin
        case (state)
          FILL: begin
            if (mode == MODE_FIXED) code[idx] <= lfsr_bit;
            if (fill_done) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          IDLE: begin
            if (accept) begin
              active_bit <= i_data;
              idx        <= '0;
              state      <= SPREAD;
            end
          end
          SPREAD: begin
            if (accept && !(chip_hs && at_last)) begin
              buf_bit   <= i_data;
              buf_valid <= 1'b1;
            end
            if (chip_hs) begin
              if (!at_last) begin
                idx <= idx + 1'b1;
              end else begin
                idx <= '0;
                if (buf_valid) begin
                  active_bit <= buf_bit;
                  buf_valid  <= 1'b0;
                end else if (accept) begin
                  active_bit <= i_data;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsss_spreader.sv
// Scoreboard bench for dsss_spreader: expected chips come from the LFSR recurrence
// s[n+9] = s[n] ^ s[n+4] over the seed, applied per bit (fixed) or continuously (running).
module tb_dsss_spreader;
  localparam int SF_MAX     = 32;
  localparam int SF_DEFAULT = 24;
  localparam int SF_W       = $clog2(SF_MAX + 1);

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic [SF_W-1:0] i_sf = '0;
  logic            i_mode = 1'b0, i_cfg_load = 1'b0, i_data = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic            o_ready, o_data, o_valid, o_last, o_busy;

  always #5 i_clk = ~i_clk;

  dsss_spreader #(.SF_MAX(SF_MAX), .SF_DEFAULT(SF_DEFAULT)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_sf      (i_sf),
    .i_mode    (i_mode),
    .i_cfg_load(i_cfg_load),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_last    (o_last),
    .o_busy    (o_busy)
  );

  typedef struct packed {logic data; logic last;} chip_t;

  chip_t exp_q[$];
  logic  log_q[$];
  int    checks = 0, errors = 0;
  bit    seq[0:1023];
  int    model_sf = SF_DEFAULT;
  bit    model_running = 1'b0;
  int    run_pos = 0;
  bit    rand_ready = 1'b0, log_on = 1'b0;
  int    valid_run = 0, max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_sf(input int v);
    if (v < 2) return 2;
    if (v > SF_MAX) return SF_MAX;
    return v;
  endfunction

  // Expected chips for one accepted bit under the current model configuration.
  task automatic push_bit(input bit b);
    chip_t c;
    for (int k = 0; k < model_sf; k++) begin
      c.data = b ^ (model_running ? seq[run_pos] : seq[k]);
      if (model_running) run_pos++;
      c.last = (k == model_sf - 1);
      exp_q.push_back(c);
    end
  endtask

  task automatic send_bit(input bit b);
    int t = 0;
    i_data  = b;
    i_valid = 1'b1;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_ready && t < 1000);
    if (!o_ready) check("accept_timeout", o_ready, 1);
    else push_bit(b);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_data  = 1'b0;
  endtask

  // Issue a config load while IDLE and measure the FILL length up to o_ready.
  task automatic cfg_idle(input int sf, input bit running);
    int cnt = 0;
    i_sf       = SF_W'(sf);
    i_mode     = running;
    i_cfg_load = 1'b1;
    @(posedge i_clk);
    #1;
    i_cfg_load    = 1'b0;
    model_sf      = clamp_sf(sf);
    model_running = running;
    run_pos       = 0;
    check("fill_ready_low", o_ready, 0);
    while (cnt < 100) begin
      @(posedge i_clk);
      #1;
      cnt++;
      if (o_ready) break;
    end
    check("fill_len", cnt, running ? 1 : clamp_sf(sf));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < 5000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", o_busy, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_busy", o_busy, 1);
  endtask

  task automatic release_and_time_fill();
    int cnt = 0;
    @(negedge i_clk);
    i_reset = 1'b0;
    while (cnt < 100) begin
      @(posedge i_clk);
      #1;
      cnt++;
      if (o_ready) break;
    end
    check("ready_after_reset", cnt, SF_DEFAULT);
  endtask

  // Monitor: pops one expected chip per output handshake, checks stall stability.
  initial begin
    chip_t c;
    bit    prev_stall = 1'b0;
    logic  prev_data = 1'b0, prev_last = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        prev_stall = 1'b0;
        valid_run  = 0;
      end else begin
        valid_run = o_valid ? valid_run + 1 : 0;
        if (valid_run > max_run) max_run = valid_run;
        if (prev_stall) begin
          check("stall_valid", o_valid, 1);
          check("stall_data", o_data, prev_data);
          check("stall_last", o_last, prev_last);
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_chip actual=%0d expected=none at %0t", o_data, $time);
          end else begin
            c = exp_q.pop_front();
            check("chip_data", o_data, c.data);
            check("chip_last", o_last, c.last);
            if (log_on) log_q.push_back(o_data);
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
        prev_last  = o_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g0, g1;
    for (int n = 0; n < 1024; n++) seq[n] = (n < 9) ? 1'b1 : (seq[n-9] ^ seq[n-5]);

    // Reset state and the power-on FILL at the default spreading factor.
    repeat (3) @(negedge i_clk);
    check_reset_outputs();
    release_and_time_fill();

    // Default SF, fixed code: bits 1 then 0.
    send_bit(1'b1);
    send_bit(1'b0);
    wait_drain();

    // SF=4 fixed, three bits back-to-back must form one gap-free run of 12 chips.
    cfg_idle(4, 1'b0);
    max_run = 0;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    wait_drain();
    check("gap_free_run", max_run, 12);

    // Running mode: two zero bits read the LFSR stream directly.
    cfg_idle(8, 1'b1);
    log_q.delete();
    log_on = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    wait_drain();
    log_on = 1'b0;
    check("run_log_len", log_q.size(), 16);
    if (log_q.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        g0[i] = log_q[i];
        g1[i] = log_q[i+8];
      end
      check("run_groups_differ", g0 != g1, 1);
    end

    // Random backpressure in both code modes.
    cfg_idle(5, 1'b0);
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)));
    wait_drain();
    rand_ready = 1'b0;
    cfg_idle(5, 1'b1);
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    wait_drain();
    rand_ready = 1'b0;

    // Clamping at both ends.
    cfg_idle(1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_drain();
    cfg_idle(40, 1'b0);
    send_bit(1'b1);
    wait_drain();

    // Config load mid-bit waits for the active and buffered bits to finish.
    cfg_idle(4, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i_sf       = SF_W'(6);
    i_mode     = 1'b1;
    i_cfg_load = 1'b1;
    @(posedge i_clk);
    #1;
    i_cfg_load    = 1'b0;
    model_sf      = 6;
    model_running = 1'b1;
    run_pos       = 0;
    begin
      int t = 0;
      while (!o_ready && t < 200) begin
        @(posedge i_clk);
        #1;
        t++;
      end
      check("deferred_ready", o_ready, 1);
      check("deferred_drained", exp_q.size(), 0);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    wait_drain();

    // Asynchronous reset at chip 3 of a bit.
    send_bit(1'b1);
    repeat (3) @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    exp_q.delete();
    model_sf      = SF_DEFAULT;
    model_running = 1'b0;
    run_pos       = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge i_clk);
    release_and_time_fill();
    send_bit(1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
